// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - Pipeline-stage register with valid/ready handshake, flush, optional skid entry and event counters
module pipe_stage_buf #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    input  logic              cnt_clr
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              accept;
    logic              emit;
    logic              stall_ev;
    logic              flush_ev;

    assign accept    = in_valid && in_ready;
    assign emit      = m_valid && out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready: the skid slot absorbs the one entry in flight when downstream stalls.
            assign in_ready = !s_valid && !flush;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    s_data  <= '0;
                end else if (flush) begin
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                end else if (emit && s_valid) begin
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                end else if (accept && m_valid && !emit) begin
                    s_valid <= 1'b1;
                    s_ctrl  <= in_ctrl;
                    s_data  <= in_data;
                end
            end
        end else begin : g_noskid
            assign in_ready = (!m_valid || out_ready) && !flush;
            assign s_valid  = 1'b0;
            assign s_ctrl   = '0;
            assign s_data   = '0;
        end
    endgenerate

    // Promotion from skid takes precedence; in_ready is low whenever the skid is occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
        end else if (emit && s_valid) begin
            m_valid <= 1'b1;
            m_ctrl  <= s_ctrl;
            m_data  <= s_data;
        end else if (accept && (!m_valid || emit)) begin
            m_valid <= 1'b1;
            m_ctrl  <= in_ctrl;
            m_data  <= in_data;
        end else if (emit) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
        end
    end

    assign stall_ev = m_valid && !out_ready;
    assign flush_ev = flush && (m_valid || s_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_ev && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - Bench for pipe_stage_buf in skid and non-skid modes against a queue model
module tb_pipe_stage_buf;

    localparam int CW    = 12;
    localparam int DW    = 32;
    localparam int MAX_A = 15;
    localparam int MAX_B = 65535;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data_a, in_data_b;
    logic          out_ready;
    logic          cnt_clr;

    logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [CW-1:0] out_ctrl_a, out_ctrl_b;
    logic [DW-1:0] out_data_a, out_data_b;
    logic [3:0]    stall_cnt_a, flush_cnt_a;
    logic [15:0]   stall_cnt_b, flush_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   sa, fa, sb, fb;
    int   nxt_a = 1;
    int   nxt_b = 1;

    always #5 clk = ~clk;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .cnt_clr(cnt_clr)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two-entry capacity with a registered ready versus one entry with pass-through ready.
    function automatic logic rdy_a();
        return (qa.size() < 2) && !flush;
    endfunction

    function automatic logic rdy_b();
        return ((qa.size() >= 0) && ((qb.size() == 0) || out_ready)) && !flush;
    endfunction

    task automatic reset_models();
        qa.delete();
        qb.delete();
        sa = 0; fa = 0; sb = 0; fb = 0;
    endtask

    task automatic check_all();
        chk("a_out_valid", 64'(out_valid_a), 64'(qa.size() > 0));
        chk("a_out_ctrl", 64'(out_ctrl_a), (qa.size() > 0) ? 64'(qa[0].c) : 64'd0);
        if (qa.size() > 0) chk("a_out_data", 64'(out_data_a), 64'(qa[0].d));
        chk("a_in_ready", 64'(in_ready_a), 64'(rdy_a()));
        chk("a_stall_cnt", 64'(stall_cnt_a), 64'(sa));
        chk("a_flush_cnt", 64'(flush_cnt_a), 64'(fa));
        chk("b_out_valid", 64'(out_valid_b), 64'(qb.size() > 0));
        chk("b_out_ctrl", 64'(out_ctrl_b), (qb.size() > 0) ? 64'(qb[0].c) : 64'd0);
        if (qb.size() > 0) chk("b_out_data", 64'(out_data_b), 64'(qb[0].d));
        chk("b_in_ready", 64'(in_ready_b), 64'(rdy_b()));
        chk("b_stall_cnt", 64'(stall_cnt_b), 64'(sb));
        chk("b_flush_cnt", 64'(flush_cnt_b), 64'(fb));
    endtask

    task automatic update_models();
        logic acc_a, acc_b, em_a, em_b;
        if (!reset) begin
            reset_models();
        end else begin
            acc_a = in_valid && rdy_a();
            acc_b = in_valid && rdy_b();
            em_a  = (qa.size() > 0) && out_ready;
            em_b  = (qb.size() > 0) && out_ready;
            if (cnt_clr) begin
                sa = 0; fa = 0; sb = 0; fb = 0;
            end else begin
                if ((qa.size() > 0) && !out_ready && sa < MAX_A) sa++;
                if ((qb.size() > 0) && !out_ready && sb < MAX_B) sb++;
                if (flush && (qa.size() > 0) && fa < MAX_A) fa++;
                if (flush && (qb.size() > 0) && fb < MAX_B) fb++;
            end
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (em_a) void'(qa.pop_front());
                if (em_b) void'(qb.pop_front());
                if (acc_a) begin qa.push_back({in_ctrl, in_data_a}); nxt_a++; end
                if (acc_b) begin qb.push_back({in_ctrl, in_data_b}); nxt_b++; end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        update_models();
        @(posedge clk);
        #1;
        in_data_a = DW'(nxt_a);
        in_data_b = DW'(nxt_b);
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic ordy,
                         input logic fl, input logic clr);
        in_valid  = v;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    initial begin
        reset = 1'b0;
        reset_models();
        drive(0, '0, 0, 0, 0);
        in_data_a = DW'(nxt_a);
        in_data_b = DW'(nxt_b);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_data_a", 64'(out_data_a), 64'd0);
        chk("rst_out_data_b", 64'(out_data_b), 64'd0);
        chk("rst_in_ready_a", 64'(in_ready_a), 64'd1);
        step();
        reset = 1'b1;

        // Stream 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            drive(1, 12'h5A5, 1, 0, 0);
            step();
        end
        drive(0, 12'h5A5, 1, 0, 0);
        repeat (3) step();
        chk("stream_stall_a", 64'(stall_cnt_a), 64'd0);
        chk("stream_stall_b", 64'(stall_cnt_b), 64'd0);

        // Four-cycle downstream stall behind one entry at the output.
        drive(1, 12'h0F1, 1, 0, 0);
        step();
        drive(1, 12'h0F2, 0, 0, 0);
        repeat (4) step();
        drive(0, 12'h0F3, 1, 0, 0);
        repeat (4) step();
        chk("stall4_a", 64'(stall_cnt_a), 64'd4);
        chk("stall4_b", 64'(stall_cnt_b), 64'd4);

        // Fill main and skid, then flush with input still offered.
        drive(1, 12'h123, 1, 0, 0);
        step();
        drive(1, 12'h124, 0, 0, 0);
        step();
        chk("full_a_depth", 64'(qa.size()), 64'd2);
        drive(1, 12'h125, 0, 1, 0);
        step();
        drive(0, 12'h000, 0, 0, 0);
        @(negedge clk);
        chk("flush_out_valid_a", 64'(out_valid_a), 64'd0);
        chk("flush_out_ctrl_a", 64'(out_ctrl_a), 64'd0);
        chk("flush_in_ready_a", 64'(in_ready_a), 64'd1);
        chk("flush_cnt_a_1", 64'(flush_cnt_a), 64'd1);
        step();
        drive(0, 12'h000, 0, 1, 0);
        step();
        drive(0, 12'h000, 1, 0, 0);
        step();
        chk("flush_empty_a", 64'(flush_cnt_a), 64'd1);

        // Saturation of the 4-bit stall counter, then clear during a stall.
        drive(1, 12'h777, 1, 0, 0);
        step();
        drive(0, 12'h777, 0, 0, 0);
        repeat (20) step();
        chk("sat_stall_a", 64'(stall_cnt_a), 64'd15);
        drive(0, 12'h777, 0, 0, 1);
        step();
        chk("clr_stall_a", 64'(stall_cnt_a), 64'd0);
        chk("clr_stall_b", 64'(stall_cnt_b), 64'd0);
        drive(0, 12'h000, 1, 0, 0);
        repeat (3) step();

        // Random traffic with occasional flushes and clears.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, CW'($urandom), ($urandom % 10) < 7,
                  ($urandom % 16) == 0, ($urandom % 32) == 0);
            step();
        end

        // Reset while entries are held drops them without emitting.
        drive(1, 12'hABC, 0, 0, 0);
        repeat (2) step();
        reset = 1'b0;
        reset_models();
        step();
        chk("midrst_out_data_a", 64'(out_data_a), 64'd0);
        chk("midrst_out_data_b", 64'(out_data_b), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 12'h3C3, 1, 0, 0);
            step();
        end
        drive(0, 12'h000, 1, 0, 0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register replacing fixed-field stall/flush stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a bundle of control bits plus a data payload with a valid/ready handshake, synchronous flush, an optional two-entry skid buffer that breaks the ready path, and saturating stall/flush event counters for performance debug. One instance sits between each pair of adjacent stages.

## Interface
- CTRL_W, 12: control-bit width (RegWrite, MemRead, MemWrite, ALUOp, …); zeroed on flush and on bubbles.
- DATA_W, 128: payload width (PC, immediates, operands, register addresses).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of each event counter.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts (0 = downstream stall).
- out_ctrl  out  CTRL_W  control bits; forced to 0 when out_valid=0.
- out_data  out  DATA_W  payload; value undefined-but-stable when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- flush_cnt  out  CNT_W  flush cycles that discarded ≥1 valid entry, saturating.
- cnt_clr  in  1  synchronous clear of both counters.

## Operation
- Storage: main entry (m_valid, m_ctrl, m_data) drives outputs; skid entry (s_valid, s_ctrl, s_data) exists only when SKID=1.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready. out_valid = m_valid.
- SKID=1: in_ready = !s_valid && !flush. On accept:
  - if main empty or emitting, write main;
  - else write skid.
  On emit with s_valid=1, skid moves to main and s_valid clears in the same edge (new accept goes to main only if skid empty, else impossible since in_ready=0).
- SKID=0: in_ready = (!m_valid || out_ready) && !flush; accept writes main.
- Emit without accept (and no skid to promote): m_valid←0, m_ctrl←0.
- flush=1: m_valid, s_valid ←0; m_ctrl, s_ctrl ←0; data registers hold. Flush beats accept/emit in the same cycle; no input is taken (in_ready=0). An emit in the flush cycle still completes downstream (downstream saw out_valid=1 and out_ready=1).
- Counters: increment by 1, saturate at 2^CNT_W−1, never wrap. cnt_clr has priority over increment (result 0). flush_cnt increments when flush && (m_valid || s_valid).
- Order preserved: skid entry is always younger than main.

## Timing
- Reset (asynchronous, reset=0): m_valid=s_valid=0, all ctrl/data registers 0, counters 0; hence out_valid=0, out_ctrl=0, out_data=0, in_ready=1 once flush=0 (SKID=1) or immediately (SKID=0, flush=0). Reset mid-transfer drops all entries without emitting.
- Latency: accept at edge N → out_valid=1 in cycle N+1 (one stage).
- Throughput: 1 entry/cycle with out_ready held 1, both modes.
- SKID=1: in_ready depends only on registers and flush; no out_ready→in_ready path. Absorbs exactly one extra entry after out_ready drops.
- SKID=0: in_ready combinationally depends on out_ready.
- Counters update on the edge ending the counted cycle; visible next cycle.

## Test plan
- Reset/stream: reset=0 then 1; drive in_valid=1, ctrl=0x5A5, data=i for i=1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, first one cycle after first accept; stall_cnt=0.
- Downstream stall, SKID=1: stream 1,2,3,…; hold out_ready=0 for 4 cycles after entry 1 reaches output -> entry 2 captured in skid, in_ready=0 next cycle, no loss/duplication, stall_cnt=4, order 1,2,3 on release.
- Same stall, SKID=0 -> in_ready falls in the same cycle as out_ready, stall_cnt=4, order preserved.
- Flush with full buffer (SKID=1, main=7, skid=8, out_ready=0): pulse flush -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1; flush on empty stage -> flush_cnt unchanged.
- Flush with simultaneous in_valid=1 -> input not accepted (in_ready=0), not emitted later.
- Counter saturation, CNT_W=4: hold out_ready=0 for 20 cycles -> stall_cnt stops at 15; cnt_clr=1 together with a stall cycle -> stall_cnt=0.
